// File: rtl/mem_arb_pkg.sv
// Shared types and default address window for the memory arbiter.
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (fixed D-over-I priority).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_t;

   localparam logic [31:0] DEF_ADDR_LO = 32'h0000_0000;
   localparam logic [31:0] DEF_ADDR_HI = 32'h0000_ffff;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester ports (I, D) and the single-port memory bus.
// slave = arbiter side, master = CPU and memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              IReq;
   logic [ADDR_W-1:0] IAddr;
   logic [DATA_W-1:0] IRdata;
   logic              IAck;
   logic              IErr;

   logic              DReq;
   logic              DWe;
   logic [ADDR_W-1:0] DAddr;
   logic [DATA_W-1:0] DWdata;
   logic [DATA_W-1:0] DRdata;
   logic              DAck;
   logic              DErr;

   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] ReadData;
   logic              MemWrite;
   logic              MemRead;

   modport slave (
      input  IReq, IAddr, DReq, DWe, DAddr, DWdata, ReadData,
      output IRdata, IAck, IErr, DRdata, DAck, DErr,
      output Address, WriteData, MemWrite, MemRead
   );

   modport master (
      output IReq, IAddr, DReq, DWe, DAddr, DWdata, ReadData,
      input  IRdata, IAck, IErr, DRdata, DAck, DErr,
      input  Address, WriteData, MemWrite, MemRead
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between I and D requesters.
// MEM_ARB_FIXED_PRIO_EN: D always wins a tie; otherwise round-robin.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic ireq,
   input  logic dreq,
   input  gnt_t last_gnt,
   output gnt_t win
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   // D beats I whenever it requests
   always_comb begin
      win = GNT_I;
      unique case (1'b1)
         dreq:    win = GNT_D;
         default: win = GNT_I;
      endcase
   end
`else
   // tie goes to the side that was not granted last
   always_comb begin
      win = GNT_I;
      unique case (1'b1)
         ireq && dreq:  win = (last_gnt == GNT_I) ? GNT_D : GNT_I;
         dreq && !ireq: win = GNT_D;
         default:       win = GNT_I;
      endcase
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a single-port word memory.
// Optional feature macro: MEM_ARB_FIXED_PRIO_EN (see mem_arb_pick).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(DEF_ADDR_LO),
   parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(DEF_ADDR_HI)
) (
   input  logic CK,
   input  logic RST,
   mem_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] SPAN = ADDR_HI - ADDR_LO;

   state_t            state;
   gnt_t              last_gnt;
   gnt_t              gnt;
   gnt_t              win;
   logic              err;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mrd;
   logic              mwr;

   logic              iack;
   logic              ierr;
   logic [DATA_W-1:0] irdata;
   logic              dack;
   logic              derr;
   logic [DATA_W-1:0] drdata;

   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_we;
   logic              req_ok;

   mem_arb_pick u_pick (
      .ireq     (bus.IReq),
      .dreq     (bus.DReq),
      .last_gnt (last_gnt),
      .win      (win)
   );

   // mux the winner's operands; window check via offset from ADDR_LO
   always_comb begin
      req_addr  = bus.IAddr;
      req_wdata = '0;
      req_we    = 1'b0;
      if (win == GNT_D) begin
         req_addr  = bus.DAddr;
         req_wdata = bus.DWdata;
         req_we    = bus.DWe;
      end
      req_ok = (req_addr - ADDR_LO) <= SPAN;
   end

   // three-phase sequencer with registered memory and ack outputs
   always_ff @(posedge CK) begin
      if (RST) begin
         state    <= IDLE;
         last_gnt <= GNT_D;
         gnt      <= GNT_I;
         err      <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mrd      <= 1'b0;
         mwr      <= 1'b0;
         iack     <= 1'b0;
         ierr     <= 1'b0;
         irdata   <= '0;
         dack     <= 1'b0;
         derr     <= 1'b0;
         drdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.IReq || bus.DReq) begin
                  gnt      <= win;
                  last_gnt <= win;
                  err      <= !req_ok;
                  addr_q   <= req_ok ? req_addr : '0;
                  wdata_q  <= (req_ok && req_we) ? req_wdata : '0;
                  mrd      <= req_ok && !req_we;
                  mwr      <= req_ok && req_we;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               addr_q  <= '0;
               wdata_q <= '0;
               mrd     <= 1'b0;
               mwr     <= 1'b0;
               if (gnt == GNT_I) begin
                  iack   <= 1'b1;
                  ierr   <= err;
                  irdata <= mrd ? bus.ReadData : '0;
               end else begin
                  dack   <= 1'b1;
                  derr   <= err;
                  drdata <= mrd ? bus.ReadData : '0;
               end
               state <= RESP;
            end
            RESP: begin
               iack   <= 1'b0;
               ierr   <= 1'b0;
               irdata <= '0;
               dack   <= 1'b0;
               derr   <= 1'b0;
               drdata <= '0;
               err    <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Address   = addr_q;
   assign bus.WriteData = wdata_q;
   assign bus.MemRead   = mrd;
   assign bus.MemWrite  = mwr;
   assign bus.IAck      = iack;
   assign bus.IErr      = ierr;
   assign bus.IRdata    = irdata;
   assign bus.DAck      = dack;
   assign bus.DErr      = derr;
   assign bus.DRdata    = drdata;

endmodule
